fijo_flotante_conv: RTL and testbench

- Sequential converter from signed two's-complement fixed-point to IEEE-754 single precision.
- Inverse of the float-to-fixed linearizer/normalizer path in the estimation system. It returns estimator fixed-point results to the floating-point domain.
- Uses a start/done handshake and a fixed 4-cycle latency. One conversion is in flight at a time.

---
 rtl/fijo_flotante_conv_pkg.sv | 24 ++
 rtl/fijo_flotante_conv_lzc.sv | 30 +++
 rtl/fijo_flotante_conv.sv | 183 ++++++++++++++++++
 tb/tb_fijo_flotante_conv.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fijo_flotante_conv_pkg.sv
// -----------------------------------------------------------------------------
// flotante_pkg
// Shared definitions for the fixed-point to IEEE-754 single precision
// converter: single-precision field widths, exponent bias and the
// converter FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package flotante_pkg;

    // Single-precision layout: 1 sign bit, 8 exponent bits, 23 mantissa bits.
    localparam int SP_EXP_W = 8;
    localparam int SP_MAN_W = 23;
    localparam int SP_BIAS  = 127;

    // One state per pipeline step of the sequential conversion.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ABS  = 3'd1,
        NORM = 3'd2,
        PACK = 3'd3,
        DONE = 3'd4
    } convState_t;

endpackage

// File: rtl/fijo_flotante_conv_lzc.sv
// -----------------------------------------------------------------------------
// lzc_fijo
// Purely combinational leading-zero counter over a W-bit vector.
// An all-zero input reports W.
// Ports:
//   data_i   [W-1:0]           vector to scan, MSB first
//   count_o  [$clog2(W):0]     number of zeros above the leading one
// -----------------------------------------------------------------------------
module lzc_fijo #(
    parameter int W = 32
) (
    input  logic [W-1:0]         data_i,
    output logic [$clog2(W):0]   count_o
);

    localparam int CW = $clog2(W) + 1;

    // Walk from the LSB upwards; the last set bit seen is the leading one,
    // so its distance from the MSB overwrites any earlier candidate. With
    // no set bit at all the default of W survives.
    always_comb begin
        count_o = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (data_i[i]) begin
                count_o = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fijo_flotante_conv.sv
// -----------------------------------------------------------------------------
// fijo_flotante_conv
// Sequential converter from signed two's-complement fixed point (W bits,
// FRAC fractional bits) to IEEE-754 single precision, rounding to nearest
// with ties to even. One conversion at a time, start/done handshake,
// result four cycles after the start request.
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   beg_i    start pulse, only looked at while idle
//   fixed_i  [W-1:0] fixed-point operand, captured with an accepted beg_i
//   busy_o   high while the conversion is being worked on
//   done_o   one-cycle pulse when float_o carries the new result
//   float_o  [31:0] {sign, exponent[7:0], mantissa[22:0]}, held between results
// -----------------------------------------------------------------------------
module fijo_flotante_conv #(
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          beg_i,
    input  logic [W-1:0]  fixed_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [31:0]   float_o
);

    import flotante_pkg::*;

    localparam int CW = $clog2(W) + 1;
    localparam int EW = W + SP_MAN_W + 1;

    // A fraction field as wide as the word (or wider) has no meaning, and the
    // width range is what the exponent arithmetic below was sized for.
    generate
        if (FRAC >= W || FRAC < 0) begin : gBadFrac
            $error("fijo_flotante_conv: FRAC must be in 0..W-1");
        end
        if (W < 8 || W > 32) begin : gBadWidth
            $error("fijo_flotante_conv: W must be in 8..32");
        end
    endgenerate

    convState_t              state_q, state_d;
    logic [W-1:0]            fixed_q, fixed_d;
    logic                    sign_q, sign_d;
    logic                    zero_q, zero_d;
    logic [W-1:0]            mag_q, mag_d;
    logic [W-1:0]            norm_q, norm_d;
    logic [SP_EXP_W-1:0]     exp_q, exp_d;
    logic [31:0]             float_q, float_d;

    logic [W-1:0]            magAbs;
    logic [CW-1:0]           lzCount;
    logic [W-1:0]            normShift;
    logic [SP_EXP_W-1:0]     expNorm;
    logic [EW-1:0]           extNorm;
    logic [SP_MAN_W-1:0]     mantRaw;
    logic                    guardBit;
    logic                    stickyBit;
    logic                    roundUp;
    logic [SP_MAN_W:0]       mantRnd;
    logic [SP_EXP_W-1:0]     expFinal;
    logic [31:0]             packedFloat;

    // Leading-zero count of the magnitude held during NORM.
    lzc_fijo #(
        .W (W)
    ) uLzc (
        .data_i  (mag_q),
        .count_o (lzCount)
    );

    // Magnitude of the captured operand. The most negative input negates
    // back onto itself, which read as unsigned is exactly 2^(W-1).
    always_comb begin
        magAbs = fixed_q[W-1] ? (~fixed_q + W'(1)) : fixed_q;
    end

    // Normalisation: move the leading one up to bit W-1 and derive the
    // biased exponent from its original position p = W-1-lz, i.e.
    // e = p - FRAC + bias. Legal W/FRAC keep e inside 1..254, so the low
    // eight bits of the signed 9-bit result are the whole story.
    always_comb begin
        normShift = mag_q << lzCount;
        expNorm   = SP_EXP_W'(W - 1 - FRAC + SP_BIAS) - SP_EXP_W'(lzCount);
    end

    // Rounding: append zeros below the normalised word so that narrow words
    // still yield 23 mantissa bits plus a guard bit. The mantissa is the 23
    // bits under the hidden one, guard is the next bit down and sticky
    // collects everything below it. A carry out of the mantissa leaves it
    // all zeros and bumps the exponent by one. A zero operand ignores all of
    // this and yields +0.
    always_comb begin
        extNorm     = {norm_q, {(SP_MAN_W + 1){1'b0}}};
        mantRaw     = extNorm[EW-2 -: SP_MAN_W];
        guardBit    = extNorm[EW-2-SP_MAN_W];
        stickyBit   = |extNorm[EW-3-SP_MAN_W:0];
        roundUp     = guardBit & (stickyBit | mantRaw[0]);
        mantRnd     = {1'b0, mantRaw} + (SP_MAN_W + 1)'(roundUp);
        expFinal    = exp_q + SP_EXP_W'(mantRnd[SP_MAN_W]);
        packedFloat = zero_q ? 32'h0000_0000
                             : {sign_q, expFinal, mantRnd[SP_MAN_W-1:0]};
    end

    // Next-state and datapath register updates. Every register holds its
    // value by default; each state only touches the stage it owns. A start
    // request outside IDLE is simply dropped.
    always_comb begin
        state_d = state_q;
        fixed_d = fixed_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        mag_d   = mag_q;
        norm_d  = norm_q;
        exp_d   = exp_q;
        float_d = float_q;
        case (state_q)
            IDLE: begin
                if (beg_i) begin
                    fixed_d = fixed_i;
                    state_d = ABS;
                end
            end
            ABS: begin
                sign_d  = fixed_q[W-1];
                mag_d   = magAbs;
                zero_d  = (magAbs == '0);
                state_d = NORM;
            end
            NORM: begin
                norm_d  = normShift;
                exp_d   = expNorm;
                state_d = PACK;
            end
            PACK: begin
                float_d = packedFloat;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything at once, which
    // also aborts any conversion in flight without producing a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fixed_q <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            norm_q  <= '0;
            exp_q   <= '0;
            float_q <= '0;
        end else begin
            state_q <= state_d;
            fixed_q <= fixed_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            mag_q   <= mag_d;
            norm_q  <= norm_d;
            exp_q   <= exp_d;
            float_q <= float_d;
        end
    end

    // Handshake outputs decode straight from the state register, so they
    // drop together with it when reset is asserted.
    always_comb begin
        busy_o  = (state_q == ABS) || (state_q == NORM) || (state_q == PACK);
        done_o  = (state_q == DONE);
        float_o = float_q;
    end

endmodule

// File: tb/tb_fijo_flotante_conv.sv
// -----------------------------------------------------------------------------
// tb_fijo_flotante_conv
// Self-checking bench for fijo_flotante_conv. Two instances (W=32/FRAC=16 and
// W=32/FRAC=0) receive identical stimulus; a reference model derived from
// plain arithmetic predicts the handshake and the rounded single-precision
// value, and a compare process checks every cycle. Directed cases pin the
// model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_fijo_flotante_conv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        beg = 1'b0;
    logic [31:0] fixedIn = 32'h0;
    logic        busyO [2];
    logic        doneO [2];
    logic [31:0] floatO [2];

    int checks = 0;
    int errors = 0;

    int          phase [2] = '{0, 0};
    logic [31:0] pend  [2] = '{32'h0, 32'h0};
    logic [31:0] last  [2] = '{32'h0, 32'h0};

    fijo_flotante_conv #(.W(32), .FRAC(16)) dutA (
        .clk     (clk),
        .rst_n   (rst_n),
        .beg_i   (beg),
        .fixed_i (fixedIn),
        .busy_o  (busyO[0]),
        .done_o  (doneO[0]),
        .float_o (floatO[0])
    );

    fijo_flotante_conv #(.W(32), .FRAC(0)) dutB (
        .clk     (clk),
        .rst_n   (rst_n),
        .beg_i   (beg),
        .fixed_i (fixedIn),
        .busy_o  (busyO[1]),
        .done_o  (doneO[1]),
        .float_o (floatO[1])
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    function automatic int fracOf(input int k);
        return (k == 0) ? 16 : 0;
    endfunction

    // Reference conversion: exact integer value divided by 2^frac, rounded
    // to 24 significant bits with ties to even.
    function automatic logic [31:0] refConv(input logic [31:0] x, input int frac);
        longint sv, m, q, r, half;
        int     p, s, e;
        logic   sgn;
        sv = longint'($signed(x));
        if (sv == 0) return 32'h0000_0000;
        sgn = (sv < 0);
        m = sgn ? -sv : sv;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        if (p > 23) begin
            s = p - 23;
            q = m >> s;
            r = m - (q << s);
            half = longint'(1) << (s - 1);
            if (r > half || (r == half && q[0])) q++;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                p++;
            end
        end else begin
            q = m << (23 - p);
        end
        e = p - frac + 127;
        return {sgn, e[7:0], q[22:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Reference model: a start is taken only while idle, the result shows
    // up four cycles after the start request with a three-cycle busy window
    // in between, and the output word then holds until the next result.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                phase[k] = 0;
                last[k]  = 32'h0;
            end else if (phase[k] == 0) begin
                if (beg) begin
                    phase[k] = 1;
                    pend[k]  = refConv(fixedIn, fracOf(k));
                end
            end else if (phase[k] == 3) begin
                phase[k] = 4;
                last[k]  = pend[k];
            end else if (phase[k] == 4) begin
                phase[k] = 0;
            end else begin
                phase[k] = phase[k] + 1;
            end
        end
    end

    // Compare process: every falling edge, both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("busy[%0d]", k), {31'b0, busyO[k]},
                        {31'b0, (phase[k] >= 1 && phase[k] <= 3)});
            checkOutput($sformatf("done[%0d]", k), {31'b0, doneO[k]},
                        {31'b0, (phase[k] == 4)});
            checkOutput($sformatf("float[%0d]", k), floatO[k], last[k]);
        end
    end

    // Hard stop in case something wedges the stimulus process.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Called on a falling edge in an idle cycle; returns on a falling edge
    // in the idle cycle that follows the result.
    task automatic applyStimulus(input logic [31:0] v, output logic [31:0] resA,
                                 output logic [31:0] resB);
        int lat;
        beg = 1'b1;
        fixedIn = v;
        @(negedge clk);
        beg = 1'b0;
        lat = 1;
        while (!doneO[0] && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'd4);
        resA = floatO[0];
        resB = floatO[1];
        @(negedge clk);
    endtask

    function automatic logic [31:0] randVal();
        logic [31:0] r;
        logic [31:0] v;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: v = r;
            1: v = {{16{r[15]}}, r[15:0]};
            2: v = r >> $urandom_range(0, 31);
            3: v = -(r >> $urandom_range(0, 31));
            default: v = (32'h1 << $urandom_range(24, 30)) | (r & 32'h0000_00FF);
        endcase
        return v;
    endfunction

    logic [31:0] resA, resB;
    logic [31:0] protoVals [6];
    logic [4:0]  busyPat;
    logic [4:0]  busyRec;
    logic [31:0] floatAtDone;
    logic        doneAtN4;
    int          cnt;
    int          spurious;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset busyA", {31'b0, busyO[0]}, 32'h0);
        checkOutput("reset doneA", {31'b0, doneO[0]}, 32'h0);
        checkOutput("reset floatA", floatO[0], 32'h0);
        checkOutput("reset floatB", floatO[1], 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed conversions with hand-computed results
        applyStimulus(32'h0001_0000, resA, resB);
        checkOutput("1.0 A", resA, 32'h3F80_0000);
        checkOutput("65536 B", resB, 32'h4780_0000);
        applyStimulus(32'hFFFF_0000, resA, resB);
        checkOutput("-1.0 A", resA, 32'hBF80_0000);
        applyStimulus(32'h0000_0000, resA, resB);
        checkOutput("zero A", resA, 32'h0000_0000);
        checkOutput("zero B", resB, 32'h0000_0000);
        applyStimulus(32'h8000_0000, resA, resB);
        checkOutput("most-neg A", resA, 32'hC700_0000);
        checkOutput("most-neg B", resB, 32'hCF00_0000);
        applyStimulus(32'h0100_0001, resA, resB);
        checkOutput("tie even B", resB, 32'h4B80_0000);
        applyStimulus(32'h0100_0003, resA, resB);
        checkOutput("tie up B", resB, 32'h4B80_0002);
        applyStimulus(32'h01FF_FFFF, resA, resB);
        checkOutput("carry B", resB, 32'h4C00_0000);

        // Protocol: beg held for six cycles while the operand keeps changing
        protoVals = '{32'h0001_0000, 32'h1111_1111, 32'h2222_2222,
                      32'h3333_3333, 32'h4444_4444, 32'h0003_0000};
        busyPat = 5'b01110;
        busyRec = 5'b0;
        floatAtDone = 32'h0;
        doneAtN4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) busyRec[i] = busyO[0];
            if (i == 4) begin
                doneAtN4 = doneO[0];
                floatAtDone = floatO[0];
            end
            beg = 1'b1;
            fixedIn = protoVals[i];
            @(negedge clk);
        end
        beg = 1'b0;
        checkOutput("proto busy pattern", {27'b0, busyRec}, {27'b0, busyPat});
        checkOutput("proto done at 4", {31'b0, doneAtN4}, 32'h1);
        checkOutput("proto first value", floatAtDone, 32'h3F80_0000);
        cnt = 0;
        while (!doneO[0] && cnt < 12) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("proto second latency", 32'(cnt), 32'd3);
        checkOutput("proto second value", floatO[0], 32'h4040_0000);
        @(negedge clk);

        // Reset asserted while NORM holds 1.0
        beg = 1'b1;
        fixedIn = 32'h0001_0000;
        @(negedge clk);
        beg = 1'b0;
        @(negedge clk);
        checkOutput("pre-reset busy", {31'b0, busyO[0]}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async busyA", {31'b0, busyO[0]}, 32'h0);
        checkOutput("async doneA", {31'b0, doneO[0]}, 32'h0);
        checkOutput("async floatA", floatO[0], 32'h0);
        checkOutput("async floatB", floatO[1], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (doneO[0] || doneO[1]) spurious++;
        end
        checkOutput("no done after reset", 32'(spurious), 32'd0);
        applyStimulus(32'h0002_0000, resA, resB);
        checkOutput("post-reset A", resA, 32'h4000_0000);
        checkOutput("post-reset B", resB, 32'h4800_0000);

        // Random operands against the reference model
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(randVal(), resA, resB);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
